// File: rtl/draw_source_sequencer.sv
// rtl/draw_source_sequencer.sv - sequences the draw sources over a shared write bus and commits their pixels to the framebuffer.
module draw_source_sequencer #(
    parameter int NUM_SOURCES       = 4,
    parameter int SOURCE_SEL_ADDRW  = 2,
    parameter int COLOR_DEPTH       = 8,
    parameter int DRAW_WIDTH        = 320,
    parameter int DRAW_HEIGHT       = 240,
    parameter int DRAW_WIDTH_ADDRW  = 9,
    parameter int DRAW_HEIGHT_ADDRW = 8,
    parameter int FB_ADDRW          = 17,
    parameter int START_TIMEOUT     = 16
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    output logic                         write_awaited,
    input  logic                         write_active,
    input  logic [COLOR_DEPTH-1:0]       write_color_data,
    input  logic                         write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
    output logic                         fb_we,
    output logic [FB_ADDRW-1:0]          fb_addr,
    output logic [COLOR_DEPTH-1:0]       fb_wdata,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         frame_overrun,
    output logic [7:0]                   skip_count
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, ACTIVE, NEXT, DONE} state_t;

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [SOURCE_SEL_ADDRW-1:0] SEL_LAST = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt;
    logic          last_sel;
    logic          timeout_hit;
    logic          in_range;
    logic          capture;
    logic [FB_ADDRW-1:0] lin_addr;

    assign last_sel    = (write_source_sel == SEL_LAST);
    assign timeout_hit = (state == WAIT_START) && !write_active && (tcnt == T_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (frame_start) state_nxt = ISSUE;
            ISSUE:      state_nxt = WAIT_START;
            WAIT_START: begin
                if (write_active)        state_nxt = ACTIVE;
                else if (tcnt == T_LAST) state_nxt = NEXT;
            end
            ACTIVE:     if (!write_active) state_nxt = NEXT;
            NEXT:       state_nxt = last_sel ? DONE : ISSUE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign write_awaited = (state == ISSUE);
    assign busy          = (state != IDLE);
    assign frame_done    = (state == DONE);
    assign frame_overrun = frame_start && (state != IDLE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            write_source_sel <= '0;
            tcnt             <= '0;
            skip_count       <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && frame_start) begin
                write_source_sel <= '0;
                skip_count       <= '0;
            end
            if (state == ISSUE)
                tcnt <= '0;
            else if (state == WAIT_START)
                tcnt <= tcnt + TW'(1);
            if (timeout_hit && skip_count != 8'hFF)
                skip_count <= skip_count + 8'd1;
            if (state == NEXT && !last_sel)
                write_source_sel <= write_source_sel + SOURCE_SEL_ADDRW'(1);
            if (state == DONE)
                write_source_sel <= '0;
        end
    end

    // One extra bit on the compare so a power-of-two extent cannot wrap.
    assign in_range = ({1'b0, write_x_addr} < (DRAW_WIDTH_ADDRW + 1)'(DRAW_WIDTH)) &&
                      ({1'b0, write_y_addr} < (DRAW_HEIGHT_ADDRW + 1)'(DRAW_HEIGHT));
    assign lin_addr = FB_ADDRW'(write_y_addr) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(write_x_addr);
    assign capture  = write_active && !write_transparent && in_range &&
                      (state == WAIT_START || state == ACTIVE);

    // An unknown capture term falls to the else branch, so X coordinates never write.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
        end else if (capture) begin
            fb_we    <= 1'b1;
            fb_addr  <= lin_addr;
            fb_wdata <= write_color_data;
        end else begin
            fb_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_draw_source_sequencer.sv
// tb/tb_draw_source_sequencer.sv - scoreboard bench for draw_source_sequencer.
module tb_draw_source_sequencer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        frame_start;
    logic [1:0]  write_source_sel;
    logic        write_awaited;
    logic        write_active;
    logic [7:0]  write_color_data;
    logic        write_transparent;
    logic [8:0]  write_x_addr;
    logic [7:0]  write_y_addr;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        busy;
    logic        frame_done;
    logic        frame_overrun;
    logic [7:0]  skip_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [24:0] sb_q[$];

    draw_source_sequencer dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start),
        .write_source_sel(write_source_sel), .write_awaited(write_awaited),
        .write_active(write_active), .write_color_data(write_color_data),
        .write_transparent(write_transparent), .write_x_addr(write_x_addr),
        .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .busy(busy), .frame_done(frame_done),
        .frame_overrun(frame_overrun), .skip_count(skip_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every framebuffer write must match the oldest expected write.
    always @(negedge clk) begin
        if (resetN && fb_we) begin
            logic [24:0] e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%0d/%0h expected=none", fb_addr, fb_wdata);
            end else begin
                e = sb_q.pop_front();
                if ({fb_addr, fb_wdata} !== e) begin
                    errors++;
                    $display("FAIL fb_write actual=%0d/%0h expected=%0d/%0h",
                             fb_addr, fb_wdata, e[24:8], e[7:0]);
                end
            end
        end
    end

    // Call at #1 after a posedge; leaves the bench at #1 after the next posedge.
    task automatic drive_px(input int x, input int y, input logic [7:0] c, input logic tr,
                            input logic ovr, input logic exp_we, input int exp_addr);
        frame_start       = ovr;
        write_active      = 1'b1;
        write_x_addr      = 9'(x);
        write_y_addr      = 8'(y);
        write_color_data  = c;
        write_transparent = tr;
        if (exp_we) sb_q.push_back({17'(exp_addr), c});
        #1;
        chk("overrun_pulse", frame_overrun, ovr);
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic end_stream();
        write_active      = 1'b0;
        write_transparent = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_awaited(input int s, output int t);
        bit seen = 0;
        t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (write_awaited) begin seen = 1; break; end
        end
        chk("awaited_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("awaited_sel", 32'(write_source_sel), 32'(s));
            chk("busy_in_pass", 32'(busy), 32'd1);
            t = cyc;
        end
    endtask

    task automatic serve(input int f, input int s);
        int a;
        if (f == 1 && s == 0) begin
            @(posedge clk); #1;
            a = 0;
            for (int y = 0; y < 240; y++)
                for (int x = 0; x < 320; x++) begin
                    drive_px(x, y, 8'h92, 1'b0, 1'b0, 1'b1, a);
                    a++;
                end
            end_stream();
        end else if (f == 2 && s == 1) begin
            @(posedge clk); #1;
            drive_px( 10,   5, 8'hA1, 1'b0, 1'b1, 1'b1, 1610);
            drive_px( 11,   5, 8'hA2, 1'b1, 1'b0, 1'b0, 0);
            drive_px( 12,   5, 8'hA3, 1'b0, 1'b0, 1'b1, 1612);
            drive_px( 13,   5, 8'hA4, 1'b0, 1'b0, 1'b1, 1613);
            drive_px(320,   5, 8'hB0, 1'b0, 1'b0, 1'b0, 0);
            drive_px(  5, 240, 8'hB1, 1'b0, 1'b0, 1'b0, 0);
            drive_px(319, 239, 8'hB2, 1'b0, 1'b0, 1'b1, 76799);
            end_stream();
        end else if (f == 2 && s == 2) begin
            // Respond on the last-but-one timeout count.
            @(posedge clk);
            repeat (14) @(posedge clk);
            #1;
            drive_px(0, 0, 8'h11, 1'b0, 1'b0, 1'b1, 0);
            end_stream();
        end
    endtask

    task automatic run_frame(input int f, input bit ovr_done, input int exp_skip,
                             input bit [3:0] silent);
        int t[5];
        bit seen = 0;
        pulse_start();
        for (int s = 0; s < 4; s++) begin
            wait_awaited(s, t[s]);
            serve(f, s);
        end
        t[4] = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done) begin seen = 1; break; end
        end
        chk("done_seen", 32'(seen), 32'd1);
        t[4] = cyc;
        if (ovr_done) frame_start = 1'b1;
        #1;
        chk("overrun_at_done", 32'(frame_overrun), 32'(ovr_done));
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("done_one_cycle", 32'(frame_done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("skip_count", 32'(skip_count), 32'(exp_skip));
        for (int s = 0; s < 4; s++)
            if (silent[s]) chk("timeout_gap", 32'(t[s+1] - t[s]), 32'd18);
        @(posedge clk); #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int t0;
        resetN = 1'b0;
        frame_start = 1'b0;
        write_active = 1'b0;
        write_color_data = '0;
        write_transparent = 1'b0;
        write_x_addr = '0;
        write_y_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        chk("rst_awaited", 32'(write_awaited), 32'd0);
        chk("rst_sel", 32'(write_source_sel), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(frame_overrun), 32'd0);
        chk("rst_skip", 32'(skip_count), 32'd0);

        run_frame(1, 1'b0, 3, 4'b1110);
        run_frame(2, 1'b1, 2, 4'b1001);

        // Reset while a source is streaming.
        pulse_start();
        wait_awaited(0, t0);
        @(posedge clk); #1;
        drive_px(0, 0, 8'h55, 1'b0, 1'b0, 1'b1, 0);
        write_x_addr = 9'd1;
        write_color_data = 8'h56;
        #5;
        chk("pre_reset_we", 32'(fb_we), 32'd1);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        resetN = 1'b0;
        #1;
        chk("reset_we", 32'(fb_we), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_awaited", 32'(write_awaited), 32'd0);
        chk("reset_sel", 32'(write_source_sel), 32'd0);
        end_stream();
        @(negedge clk);
        resetN = 1'b1;
        run_frame(4, 1'b0, 4, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_source_sequencer.md
Name: draw_source_sequencer

Overview:
Downstream and controlling stage for the draw sources (background drawer, sprite drawers, etc.) that share the write_* bus.
- Per frame, selects each source in turn via write_source_sel and issues a one-cycle write_awaited request.
- While a source is active, it captures that source's pixel stream and commits it to the framebuffer write port. Transparent pixels are dropped.
- Signals frame completion to the buffer-swap logic.

Parameters:
NUM_SOURCES, 4, number of draw sources; sequenced in order 0..NUM_SOURCES-1
SOURCE_SEL_ADDRW, 2, width of write_source_sel
COLOR_DEPTH, 8, pixel colour width
DRAW_WIDTH, 320, drawable columns
DRAW_HEIGHT, 240, drawable rows
DRAW_WIDTH_ADDRW, 9, column address width
DRAW_HEIGHT_ADDRW, 8, row address width
FB_ADDRW, 17, framebuffer linear address width
START_TIMEOUT, 16, cycles to wait for write_active after a request before skipping the source

Ports:
clk  in  1  clock
resetN  in  1  reset, asynchronous, active-low
frame_start  in  1  one-cycle pulse; starts a compose pass
write_source_sel  out  SOURCE_SEL_ADDRW  selected source
write_awaited  out  1  one-cycle request to the selected source
write_active  in  1  selected source is streaming pixels
write_color_data  in  COLOR_DEPTH  pixel colour
write_transparent  in  1  pixel must not be written
write_x_addr  in  DRAW_WIDTH_ADDRW  pixel column
write_y_addr  in  DRAW_HEIGHT_ADDRW  pixel row
fb_we  out  1  framebuffer write enable
fb_addr  out  FB_ADDRW  y*DRAW_WIDTH + x
fb_wdata  out  COLOR_DEPTH  framebuffer write data
busy  out  1  compose pass in progress
frame_done  out  1  one-cycle pulse at end of pass
frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy
skip_count  out  8  saturating count of timed-out sources in the current/last pass

Behaviour:
- Reset values: state IDLE, write_source_sel=0, write_awaited=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, frame_done=0, frame_overrun=0, skip_count=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT_START, ACTIVE, NEXT, DONE.
- IDLE:
  - frame_start -> ISSUE.
  - On entering ISSUE: sel=0, skip_count cleared.
- ISSUE: write_awaited=1 for exactly this cycle; timeout counter cleared; -> WAIT_START.
- WAIT_START:
  - write_active=1 -> ACTIVE.
  - Otherwise counter increments.
  - Counter reaching START_TIMEOUT-1 without write_active -> skip_count+1 (saturate at 255), then -> NEXT.
- ACTIVE: stays while write_active=1; write_active=0 -> NEXT.
- NEXT:
  - If sel==NUM_SOURCES-1 -> DONE.
  - Else sel+1 and -> ISSUE.
- DONE: frame_done=1 for one cycle; -> IDLE. sel returns to 0.
- busy=1 in every state except IDLE.
- write_source_sel is held stable from ISSUE through NEXT. It changes only on the NEXT->ISSUE transition or on return to IDLE.
- Pixel capture, registered, latency 1 cycle:
  - fb_we(t+1) = write_active(t) & ~write_transparent(t) & (x<DRAW_WIDTH) & (y<DRAW_HEIGHT) & state(t)∈{WAIT_START,ACTIVE}.
  - fb_addr and fb_wdata are registered from the same cycle.
  - Out-of-range or unknown x/y never produce a write.
- fb_addr = y*DRAW_WIDTH + x, computed at FB_ADDRW width with no truncation for in-range coordinates. Maximum is 76799.
- A pixel presented in the same cycle the FSM leaves ACTIVE is still captured. The last pixel of a source is never lost.
- frame_start while busy: ignored. frame_overrun pulses for that cycle; the pass in progress is unaffected.
- frame_start coincident with DONE: treated as busy, so overrun.
- Sources are always serviced in index order. Later sources overwrite earlier ones, which gives painter's-algorithm layering.
- A source that never drops write_active hangs the pass. This is by design; there is no active-phase timeout.
- Reset mid-pass: immediate return to the reset values, and any in-flight fb_we is cancelled.

Test Plan:
- Reset, then frame_start with source 0 a background drawer (colour 0x92, 320x240) and sources 1–3 silent -> write_awaited pulses with sel=0; 76800 fb_we writes of 0x92, addresses 0..76799 in order; then 3 timeouts, skip_count=3, frame_done one cycle.
- Source 1 streams 4 pixels at (10,5),(11,5),(12,5),(13,5), with the second flagged transparent -> exactly 3 writes at addresses 1610, 1612, 1613.
- Source streams x=320 or y=240 -> no fb_we for those pixels.
- frame_start pulsed again mid-pass -> frame_overrun=1 for one cycle; sel sequence and frame_done timing unchanged.
- Source responds to write_awaited after exactly START_TIMEOUT-2 idle cycles -> accepted, no skip. A source that never responds is skipped after exactly START_TIMEOUT cycles in WAIT_START.
- resetN asserted during ACTIVE -> fb_we=0 and busy=0 immediately; the next frame_start restarts at sel=0.
